// File: rtl/enc_stream_ctrl.sv
// enc_stream_ctrl: registered SECDED (extended Hamming) encoder with a 2-entry
// skid buffer and valid/ready handshaking on both sides.
//
// Optional feature macro: ENC_ERR_INJECT_EN
//   defined   -> adds port inj_mask, XORed into each stored codeword at accept
//   undefined -> pure encoding, no inj_mask port
//
// Codeword layout: codeword[i] (i < DATA_WIDTH-1) is Hamming position i+1,
// power-of-two positions carry check bits, the rest carry data_in in ascending
// order; the MSB is even overall parity across the lower bits.

module enc_stream_ctrl #(
    parameter int DATA_WIDTH = 32,
    localparam int K = (DATA_WIDTH == 8) ? 4 : (DATA_WIDTH == 16) ? 11 : 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K-1:0]          data_in,
`ifdef ENC_ERR_INJECT_EN
    input  logic [DATA_WIDTH-1:0] inj_mask,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] codeword_out,
    output logic [15:0]           word_cnt
);

    // Number of Hamming check bits and Hamming positions (overall parity excluded)
    localparam int P = (DATA_WIDTH == 8) ? 3 : (DATA_WIDTH == 16) ? 4 : 5;
    localparam int N = DATA_WIDTH - 1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Hamming position (1-based) that carries data bit idx.
    function automatic int data_pos(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (cnt == idx) res = pos;
                cnt++;
            end
        end
        return res;
    endfunction

    // Data positions covered by the check bit at position 2^j.
    function automatic logic [N-1:0] check_mask(input int j);
        logic [N-1:0] m;
        m = '0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((((pos >> j) & 1) == 1) && ((pos & (pos - 1)) != 0)) m[pos-1] = 1'b1;
        end
        return m;
    endfunction

    logic [N-1:0]            data_vec;  // data bits scattered, zeros at check positions
    logic [N-1:0]            ham_vec;   // full Hamming word, positions 1..N
    logic [DATA_WIDTH-1:0]   enc_word;
    logic [DATA_WIDTH-1:0]   store_word;

    logic [1:0]              state_q, state_d;
    logic [DATA_WIDTH-1:0]   main_q, main_d;
    logic [DATA_WIDTH-1:0]   skid_q, skid_d;
    logic                    valid_q;
    logic                    room_q;    // registered "state != TWO", cleared by reset
    logic [15:0]             cnt_q;

    logic                    accept;
    logic                    drain;

    // Scatter data bits into their Hamming positions
    for (genvar k = 0; k < K; k++) begin : g_data
        assign data_vec[data_pos(k)-1] = data_in[k];
        assign ham_vec[data_pos(k)-1]  = data_in[k];
    end

    // Check bits from the data positions each one covers
    for (genvar j = 0; j < P; j++) begin : g_chk
        localparam logic [N-1:0] Mask = check_mask(j);
        assign data_vec[(1<<j)-1] = 1'b0;
        assign ham_vec[(1<<j)-1]  = ^(data_vec & Mask);
    end

    assign enc_word = {^ham_vec, ham_vec};

`ifdef ENC_ERR_INJECT_EN
    assign store_word = enc_word ^ inj_mask;
`else
    assign store_word = enc_word;
`endif

    assign in_ready     = enable && room_q;
    assign out_valid    = valid_q;
    assign codeword_out = main_q;
    assign word_cnt     = cnt_q;

    assign accept = in_valid && in_ready;
    assign drain  = valid_q && out_ready;

    // Next-state and slot updates for the MAIN/SKID buffer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = store_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    skid_d  = store_word;
                    state_d = ST_TWO;
                end else if (drain && !accept) begin
                    state_d = ST_EMPTY;
                end else if (accept && drain) begin
                    main_d = store_word;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen
                if (drain) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State, storage and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            room_q  <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= (state_d != ST_EMPTY);
            room_q  <= (state_d != ST_TWO);
            if (drain) cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_enc_stream_ctrl.sv
// Self-checking bench for enc_stream_ctrl (DATA_WIDTH=8): directed cases plus
// randomized traffic against a queue-based reference model.
// ENC_ERR_INJECT_EN, when defined, also exercises inj_mask.

module tb_enc_stream_ctrl;

    localparam int DW = 8;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [KW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] codeword_out;
    logic [DW-1:0] inj_mask;
    logic [15:0]   word_cnt;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    logic [15:0]   m_cnt;
    bit            do_check = 1'b1;

    enc_stream_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
`ifdef ENC_ERR_INJECT_EN
        .inj_mask     (inj_mask),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .codeword_out (codeword_out),
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Extended Hamming encode straight from the layout rules
    function automatic logic [DW-1:0] ref_enc(input logic [KW-1:0] d);
        logic [DW-1:0] cw;
        int di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos < DW; pos++) begin
            if (!is_pow2(pos)) begin
                cw[pos-1] = d[di];
                di++;
            end
        end
        for (int pos = 1; pos < DW; pos++) begin
            if (!is_pow2(pos)) begin
                for (int j = 0; (1 << j) < DW; j++) begin
                    if (pos[j]) cw[(1<<j)-1] = cw[(1<<j)-1] ^ cw[pos-1];
                end
            end
        end
        cw[DW-1] = ^cw[DW-2:0];
        return cw;
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, enable && (exp_q.size() < 2)});
        if (exp_q.size() > 0) check_eq("codeword", {24'd0, codeword_out}, {24'd0, exp_q[0]});
        check_eq("word_cnt", {16'd0, word_cnt}, {16'd0, m_cnt});
    endtask

    // Apply one cycle of inputs, advance the model, then check at the negedge
    task automatic cycle(input logic en, input logic iv, input logic [KW-1:0] d,
                         input logic ordy);
        bit acc;
        bit drn;
        logic [DW-1:0] w;
        enable    = en;
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
        acc = iv && en && (exp_q.size() < 2);
        drn = (exp_q.size() > 0) && ordy;
        if (drn) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        w = ref_enc(d);
`ifdef ENC_ERR_INJECT_EN
        w = w ^ inj_mask;
`endif
        if (acc) exp_q.push_back(w);
        @(posedge clk);
        @(negedge clk);
        if (do_check) check_outputs();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        m_cnt = 16'h0000;
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_cw", {24'd0, codeword_out}, 32'd0);
        check_eq("rst_cnt", {16'd0, word_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rel_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        inj_mask = '0;
        do_reset();

        // Single word, immediate drain
        cycle(1'b1, 1'b1, 4'b1011, 1'b1);
        check_eq("t1_cw", {24'd0, codeword_out}, 32'h55);
        cycle(1'b1, 1'b0, 4'h0, 1'b1);
        check_eq("t1_cnt", {16'd0, word_cnt}, 32'd1);

        // Back-to-back extremes
        cycle(1'b1, 1'b1, 4'h0, 1'b1);
        check_eq("t2_cw0", {24'd0, codeword_out}, 32'h00);
        cycle(1'b1, 1'b1, 4'hF, 1'b1);
        check_eq("t2_cwF", {24'd0, codeword_out}, 32'hFF);
        check_eq("t2_ready", {31'd0, in_ready}, 32'd1);
        cycle(1'b1, 1'b0, 4'h0, 1'b1);

        // Backpressure: fill to TWO, then release
        cycle(1'b1, 1'b1, 4'h3, 1'b0);
        cycle(1'b1, 1'b1, 4'h9, 1'b0);
        check_eq("t3_full", {31'd0, in_ready}, 32'd0);
        cycle(1'b1, 1'b1, 4'h6, 1'b0);
        check_eq("t3_hold", {24'd0, codeword_out}, {24'd0, ref_enc(4'h3)});
        cycle(1'b1, 1'b1, 4'h6, 1'b1);
        check_eq("t3_second", {24'd0, codeword_out}, {24'd0, ref_enc(4'h9)});
        cycle(1'b1, 1'b1, 4'h6, 1'b1);
        check_eq("t3_third", {24'd0, codeword_out}, {24'd0, ref_enc(4'h6)});
        cycle(1'b1, 1'b0, 4'h0, 1'b1);

        // Reset while in TWO discards both words
        cycle(1'b1, 1'b1, 4'hA, 1'b0);
        cycle(1'b1, 1'b1, 4'h5, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);

`ifdef ENC_ERR_INJECT_EN
        inj_mask = 8'h01;
        cycle(1'b1, 1'b1, 4'b1011, 1'b0);
        check_eq("inj_flip", {24'd0, codeword_out}, 32'h54);
        inj_mask = 8'h00;
        cycle(1'b1, 1'b0, 4'h0, 1'b1);
        cycle(1'b1, 1'b1, 4'b1011, 1'b0);
        check_eq("inj_none", {24'd0, codeword_out}, 32'h55);
        cycle(1'b1, 1'b0, 4'h0, 1'b1);
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                  KW'($urandom_range(0, (1 << KW) - 1)), $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 4'h7, 1'b1);

        // Run word_cnt up to 16'hFFFF, then one more drain wraps it
        do_check = 1'b0;
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
            cycle(1'b1, 1'b1, KW'($urandom_range(0, (1 << KW) - 1)), 1'b1);
        end
        do_check = 1'b1;
        check_eq("cnt_ffff", {16'd0, word_cnt}, 32'h0000FFFF);
        cycle(1'b1, 1'b1, 4'h1, 1'b1);
        check_eq("cnt_wrap", {16'd0, word_cnt}, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
